// File: rtl/nes_pkg.sv
// Shared constants, button bit positions and FSM state encoding for the NES controller reader.
package nes_pkg;

  localparam logic [4:0]  NO_BUTTON = 5'd12;
  localparam int unsigned NUM_PAGES = 3;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LATCH  = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_UPDATE = 2'd3
  } nes_state_t;

  // Page sequence 0 -> 1 -> 2 -> 0
  function automatic logic [1:0] next_page(input logic [1:0] p);
    return (p == 2'(NUM_PAGES - 1)) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/nes_bit_timer.sv
// Half-bit phase timer: counts HALF_CYC cycles per phase, two phases per bit, and tracks the bit index.
module nes_bit_timer #(
  parameter int unsigned HALF_CYC = 72
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_run,
  output logic       o_half_end_c,
  output logic       o_phase,
  output logic [2:0] o_bit
);

  localparam int unsigned HALF_W = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;

  logic [HALF_W-1:0] r_cnt;
  logic              r_phase;
  logic [2:0]        r_bit;

  assign o_half_end_c = i_run && (r_cnt == HALF_W'(HALF_CYC - 1));
  assign o_phase      = r_phase;
  assign o_bit        = r_bit;

  // Holds at zero while idle so every frame starts from a clean phase
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_bit   <= 3'd0;
    end else if (!i_run) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
      r_bit   <= 3'd0;
    end else if (o_half_end_c) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
      if (r_phase) r_bit <= r_bit + 3'd1;
    end else begin
      r_cnt <= r_cnt + HALF_W'(1);
    end
  end

endmodule

// File: rtl/nes_reader.sv
// NES controller poller: latches and shifts 8 buttons, maps d-pad + page to a code.
// Build option NES_DEBOUNCE_EN: accept a button vector only after two identical consecutive polls.
module nes_reader
  import nes_pkg::*;
#(
  parameter int unsigned HALF_CYC = 72,
  parameter int unsigned POLL_CYC = 200000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       nes_data,
  output logic       nes_latch,
  output logic       nes_clk,
  output logic [4:0] nes_code,
  output logic [1:0] page,
  output logic       code_new
);

  localparam int unsigned POLL_W = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;

  nes_state_t        r_state;
  logic [POLL_W-1:0] r_poll_cnt;
  logic              r_nes_latch;
  logic              r_nes_clk;
  logic [4:0]        r_code;
  logic [1:0]        r_page;
  logic              r_code_new;
  logic [7:0]        r_shift;
  logic              r_prev_sel;

  logic              w_poll_tick;
  logic              w_half_end;
  logic              w_phase;
  logic [2:0]        w_bit;
  logic              w_accept;
  logic              w_dir_valid;
  logic [1:0]        w_dir;
  logic [1:0]        w_page_next;
  logic [4:0]        w_code_next;

  assign nes_latch = r_nes_latch;
  assign nes_clk   = r_nes_clk;
  assign nes_code  = r_code;
  assign page      = r_page;
  assign code_new  = r_code_new;

  nes_bit_timer #(.HALF_CYC(HALF_CYC)) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_run        ((r_state == ST_LATCH) || (r_state == ST_SHIFT)),
    .o_half_end_c (w_half_end),
    .o_phase      (w_phase),
    .o_bit        (w_bit)
  );

  // Free-running poll counter; ticks arriving outside IDLE are simply lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_poll_cnt <= '0;
    else if (w_poll_tick) r_poll_cnt <= '0;
    else r_poll_cnt <= r_poll_cnt + POLL_W'(1);
  end

  assign w_poll_tick = (r_poll_cnt == POLL_W'(POLL_CYC - 1));

`ifdef NES_DEBOUNCE_EN
  logic [7:0] r_prev_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prev_raw <= '0;
    else if (r_state == ST_UPDATE) r_prev_raw <= r_shift;
  end

  assign w_accept = (r_shift == r_prev_raw);
`else
  logic w_unused_btn;

  assign w_accept     = 1'b1;
  assign w_unused_btn = ^{r_shift[BTN_A], r_shift[BTN_B], r_shift[BTN_START]};
`endif

  // Direction priority Up > Down > Left > Right
  always_comb begin
    w_dir_valid = 1'b1;
    w_dir       = 2'd0;
    if (r_shift[BTN_UP])         w_dir = 2'd0;
    else if (r_shift[BTN_DOWN])  w_dir = 2'd1;
    else if (r_shift[BTN_LEFT])  w_dir = 2'd2;
    else if (r_shift[BTN_RIGHT]) w_dir = 2'd3;
    else                         w_dir_valid = 1'b0;
  end

  assign w_page_next = (r_shift[BTN_SELECT] && !r_prev_sel) ? next_page(r_page) : r_page;
  assign w_code_next = w_dir_valid ? 5'({w_page_next, w_dir}) : NO_BUTTON;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_nes_latch <= 1'b0;
      r_nes_clk   <= 1'b1;
      r_code      <= NO_BUTTON;
      r_page      <= 2'd0;
      r_code_new  <= 1'b0;
      r_shift     <= '0;
      r_prev_sel  <= 1'b0;
    end else begin
      r_code_new <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_poll_tick) begin
            r_state     <= ST_LATCH;
            r_nes_latch <= 1'b1;
            r_nes_clk   <= 1'b1;
          end
        end
        ST_LATCH: begin
          if (w_half_end && w_phase) begin
            r_shift[BTN_A] <= ~nes_data;
            r_nes_latch    <= 1'b0;
            r_nes_clk      <= 1'b0;
            r_state        <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Low half then high half; the controller's data is stable by the end of the high half
          if (w_half_end) begin
            if (!w_phase) begin
              r_nes_clk <= 1'b1;
            end else begin
              r_shift[w_bit] <= ~nes_data;
              if (w_bit == 3'd7) r_state <= ST_UPDATE;
              else r_nes_clk <= 1'b0;
            end
          end
        end
        ST_UPDATE: begin
          r_state <= ST_IDLE;
          if (w_accept) begin
            r_page     <= w_page_next;
            r_code     <= w_code_next;
            r_code_new <= (w_code_next != r_code);
            r_prev_sel <= r_shift[BTN_SELECT];
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/nes_reader.md
NES_READER -- requirements
Module: nes_reader

Interface
REQ-001 SHALL have parameter HALF_CYC, default 72, meaning clk cycles per NES half-bit (6 us at 12 MHz).
REQ-002 SHALL have parameter POLL_CYC, default 200000, meaning clk cycles between poll starts (60 Hz at 12 MHz; must exceed 20*HALF_CYC).
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port nes_data, input, 1, controller serial data, active-low (0 = pressed).
REQ-006 SHALL have port nes_latch, output, 1, controller latch strobe, active-high.
REQ-007 SHALL have port nes_clk, output, 1, controller shift clock, idle high.
REQ-008 SHALL have port nes_code, output, 5, button code {page,dir} 0..11, or 12 = none.
REQ-009 SHALL have port page, output, 2, current device page 0..2.
REQ-010 SHALL have port code_new, output, 1, one-cycle pulse when nes_code changes.

Function
REQ-011 SHALL run FSM IDLE -> LATCH -> SHIFT -> UPDATE -> IDLE.
REQ-012 IDLE: poll counter counts to POLL_CYC-1, then wraps to 0 and enters LATCH.
REQ-013 LATCH: nes_latch high for exactly 2*HALF_CYC cycles, nes_clk high; sample nes_data on the last LATCH cycle as bit 0 (A).
REQ-014 SHIFT: 7 periods; each drives nes_clk low for HALF_CYC, then high for HALF_CYC; sample nes_data on the last high cycle of each period into bits 1..7 (B, Select, Start, Up, Down, Left, Right).
REQ-015 Sampled bits SHALL be inverted so that 1 = pressed.
REQ-016 UPDATE (1 cycle): dir = Up 0, Down 1, Left 2, Right 3; priority Up > Down > Left > Right; no direction pressed -> nes_code = 12; else nes_code = 4*page + dir.
REQ-017 Select newly pressed (previous accepted poll released, this poll pressed) SHALL advance page 0->1->2->0; nes_code in the same UPDATE uses the new page.
REQ-018 Select held across polls SHALL NOT advance page again; A, B and Start SHALL be ignored.
REQ-019 code_new SHALL pulse on the cycle after UPDATE iff nes_code differs from its prior value.
REQ-020 nes_code SHALL never hold a value in 13..31.
REQ-021 The poll counter SHALL run continuously, independent of FSM state; a poll tick arriving outside IDLE SHALL be dropped, not queued.

Reset
REQ-022 Reset (async assert, sync deassert): state IDLE, nes_latch 0, nes_clk 1, nes_code 12, page 0, code_new 0, counters 0, previous-button register all released.
REQ-023 Reset asserted mid-SHIFT SHALL abort the frame with no update to nes_code or page.
REQ-024 First LATCH SHALL start POLL_CYC cycles after reset release.

Configuration
REQ-025 With NES_DEBOUNCE_EN defined: a button vector SHALL be accepted only when two consecutive polls are identical; otherwise UPDATE leaves all outputs unchanged.
REQ-026 Without NES_DEBOUNCE_EN: every poll's vector SHALL be accepted immediately.

Structure
REQ-027 Package nes_pkg SHALL hold NO_BUTTON = 5'd12, NUM_PAGES = 3, button bit indices (A=0 ... Right=7), and the FSM state enum.
REQ-028 Sub-module nes_bit_timer SHALL generate the HALF_CYC phase ticks and bit count; the FSM remains in nes_reader.

Verification
REQ-029 Reset, no buttons (nes_data = 1) -> nes_code 12, page 0, code_new never pulses, latch period POLL_CYC.
REQ-030 Controller model holds Up -> after first accepted poll nes_code 0, one code_new pulse; Up + Right held -> still 0 (priority).
REQ-031 Select pressed for 3 separate polls with release polls between, Left held -> page 1, 2, 0; nes_code 6, 10, 2.
REQ-032 Select held for 5 polls -> page advances exactly once.
REQ-033 Reset asserted mid-SHIFT with Down pressed -> nes_code 12, page 0, nes_clk 1 immediately.
REQ-034 NES_DEBOUNCE_EN, Right pressed for one poll only -> nes_code stays 12; two consecutive polls -> nes_code 3.
